// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO read port between the UART receiver and the register block.
// Head data is first-word-fall-through; rd_en pops on the next clk_bus edge.
// The reader may stall indefinitely; the receiver drops on full and flags overrun.
interface uart_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic               rd_en;
  logic [10:0]        rd_data;
  logic               rd_valid;
  logic [FIFO_AW:0]   fifo_level;

  modport master (output rd_en, input rd_data, input rd_valid, input fifo_level);
  modport slave  (input rd_en, output rd_data, output rd_valid, output fifo_level);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-8 data bits, parity, 1/2 stop) with per-character flags and an RX FIFO.
// Line fall to push: (1+N+P+S)*div + 2 cycles; rd_valid/fifo_level follow one edge later.
// No backpressure on the line: a character arriving at a full FIFO is dropped and sets overrun.
module uart_rx_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic             clk_bus,
  input  logic             rst,
  input  logic             rxd_in,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             overrun,
  input  logic             clear_overrun,
  uart_rx_fifo_if.slave    rd
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t state, state_nxt;

  logic             rxd_m, rxd_s;
  logic [DIV_W-1:0] div_in, div_r, cnt, q_pt, h_pt;
  logic [2:0]       last_bit, bit_idx;
  logic             par_en, par_odd, two_stop, stop_idx;
  logic             s_a, s_b, s_c, maj, bit_end;
  logic [7:0]       data_r;
  logic             par_bit, par_err, frame_err;
  logic             fe_now, brk_now, last_stop, start_det, push;
  logic [10:0]      entry;

  // FIFO state
  logic [10:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               empty, full, do_pop, do_push, drop;

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd_in;
      rxd_s <= rxd_m;
    end
  end

  assign div_in    = (divisor < DIV_W'(8)) ? DIV_W'(8) : divisor;
  assign q_pt      = div_r >> 2;
  assign h_pt      = div_r >> 1;
  assign bit_end   = (cnt == div_r - DIV_W'(1));
  assign maj       = (s_a & s_b) | (s_a & s_c) | (s_b & s_c);
  assign start_det = (state == S_IDLE) && !rxd_s;
  assign last_stop = !two_stop || stop_idx;
  assign fe_now    = frame_err | ~maj;
  assign brk_now   = fe_now && (data_r == 8'd0) && !(par_en && par_bit);
  assign entry     = {brk_now, fe_now, par_err, data_r};

  // State register
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and push strobe at the end of the last stop bit
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE:      if (!rxd_s) state_nxt = S_START;
      S_START:     if (bit_end) state_nxt = maj ? S_IDLE : S_DATA;
      S_DATA:      if (bit_end && bit_idx == last_bit) state_nxt = par_en ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_end && last_stop) begin
          push      = 1'b1;
          state_nxt = fe_now ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: if (rxd_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bit timer; the start-detect cycle counts as cnt 0 of the start bit
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE || state == S_WAIT_HIGH) begin
      cnt <= start_det ? DIV_W'(1) : '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Three samples per bit at 1/4, 1/2 and 3/4 of the bit period
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
      s_c <= 1'b1;
    end else begin
      if (cnt == q_pt)        s_a <= rxd_s;
      if (cnt == h_pt)        s_b <= rxd_s;
      if (cnt == q_pt + h_pt) s_c <= rxd_s;
    end
  end

  // Frame format capture at start detect, then data/parity/stop accumulation
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      div_r     <= DIV_W'(8);
      last_bit  <= 3'd7;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      two_stop  <= 1'b0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      data_r    <= 8'd0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else if (start_det) begin
      div_r     <= div_in;
      last_bit  <= 3'd4 + {1'b0, data_bits};
      par_en    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_odd   <= (parity_mode == 2'b01);
      two_stop  <= stop2;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      data_r    <= 8'd0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else if (bit_end) begin
      case (state)
        S_DATA: begin
          data_r[bit_idx] <= maj;
          bit_idx         <= bit_idx + 3'd1;
        end
        S_PARITY: begin
          par_bit <= maj;
          // even: total ones must be even; odd: total ones must be odd
          par_err <= (^data_r) ^ maj ^ par_odd;
        end
        S_STOP: begin
          frame_err <= fe_now;
          stop_idx  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = rd.rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_bus) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers and full-width occupancy count
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear wins
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst)                overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

  assign rd.rd_data    = empty ? 11'd0 : mem[rd_ptr];
  assign rd.rd_valid   = !empty;
  assign rd.fifo_level = level;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue scoreboard fed by a frame-level model.
// Stimulus serialises characters on rxd_in; a monitor drains and compares FIFO entries.
// Reads are stalled on demand to exercise full/overrun and simultaneous push/pop.
module tb_uart_rx_fifo;
  localparam int FIFO_AW = 4;
  localparam int DIV_W   = 16;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic             clk_bus, rst, rxd_in, stop2, clear_overrun, overrun;
  logic [DIV_W-1:0] divisor;
  logic [1:0]       data_bits, parity_mode;
  logic             mon_pop, man_pop, auto_rd;

  int          n_cmp, n_err, n_popped, cur_div;
  bit          model_ovr;
  logic [10:0] exp_q [$];

  uart_rx_fifo_if #(.FIFO_AW(FIFO_AW)) rif ();
  assign rif.rd_en = mon_pop | man_pop;

  uart_rx_fifo #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
    .clk_bus       (clk_bus),
    .rst           (rst),
    .rxd_in        (rxd_in),
    .divisor       (divisor),
    .data_bits     (data_bits),
    .parity_mode   (parity_mode),
    .stop2         (stop2),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .rd            (rif.slave)
  );

  initial begin
    clk_bus = 1'b0;
    forever #5 clk_bus = ~clk_bus;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever reading is enabled and an entry is presented
  initial begin
    mon_pop = 1'b0;
    forever begin
      @(negedge clk_bus);
      if (auto_rd && rif.rd_valid && !rst) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_entry: got 0x%0h, expected no entry", rif.rd_data);
        end else begin
          check("rx_entry", 32'(rif.rd_data), 32'(exp_q.pop_front()));
        end
        n_popped++;
        mon_pop = 1'b1;
      end else begin
        mon_pop = 1'b0;
      end
    end
  end

  // Reference model: parity bit a correct transmitter would send
  function automatic bit tx_parity(input logic [7:0] dm, input int pm);
    int ones;
    ones = $countones(dm);
    return (pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  // Reference model: FIFO entry for one transmitted frame
  function automatic logic [10:0] expect_entry(input logic [7:0] d, input int nb, input int pm,
                                               input bit s2, input bit flip, input bit st1, input bit st2);
    logic [7:0] mask, dm;
    bit pen, pbit, pe, fe, brk;
    mask = 8'((1 << nb) - 1);
    dm   = d & mask;
    pen  = (pm == 1) || (pm == 2);
    pbit = tx_parity(dm, pm) ^ flip;
    pe   = pen && flip;
    fe   = !st1 || (s2 && !st2);
    brk  = fe && (dm == 8'd0) && !(pen && pbit);
    return {brk, fe, pe, dm};
  endfunction

  task automatic set_div(input int d);
    divisor = DIV_W'(d);
    cur_div = (d < 8) ? 8 : d;
  endtask

  task automatic drive_bit(input bit v);
    rxd_in = v;
    repeat (cur_div) @(posedge clk_bus);
    #1;
  endtask

  task automatic idle(input int n);
    rxd_in = 1'b1;
    repeat (n) @(posedge clk_bus);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int pm, input bit s2,
                            input bit flip, input bit st1, input bit st2, output logic [10:0] e);
    logic [7:0] dm;
    dm          = d & 8'((1 << nb) - 1);
    data_bits   = 2'(nb - 5);
    parity_mode = 2'(pm);
    stop2       = s2;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pm == 1 || pm == 2) drive_bit(tx_parity(dm, pm) ^ flip);
    drive_bit(st1);
    if (s2) drive_bit(st2);
    rxd_in = 1'b1;
    e = expect_entry(d, nb, pm, s2, flip, st1, st2);
  endtask

  task automatic model_push(input logic [10:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else model_ovr = 1'b1;
  endtask

  task automatic send_push(input logic [7:0] d, input int nb, input int pm, input bit s2,
                           input bit flip, input bit st1, input bit st2);
    logic [10:0] e;
    send_frame(d, nb, pm, s2, flip, st1, st2, e);
    model_push(e);
  endtask

  task automatic drain();
    int t;
    auto_rd = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || rif.rd_valid) && t < 3000) begin
      @(posedge clk_bus);
      #1;
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d entries outstanding, expected 0", exp_q.size());
    end
    check("drain_level", 32'(rif.fifo_level), 32'd0);
  endtask

  initial begin
    logic [10:0] e17;
    int lat, p0;
    n_cmp = 0; n_err = 0; n_popped = 0; model_ovr = 1'b0;
    rst = 1'b1; rxd_in = 1'b1; clear_overrun = 1'b0;
    man_pop = 1'b0; auto_rd = 1'b0;
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    set_div(16);
    repeat (3) @(posedge clk_bus);
    #1;
    check("reset_rd_valid", 32'(rif.rd_valid), 32'd0);
    check("reset_level",    32'(rif.fifo_level), 32'd0);
    check("reset_overrun",  32'(overrun), 32'd0);
    check("reset_rd_data",  32'(rif.rd_data), 32'd0);
    rst = 1'b0;
    idle(5);

    // 8N1 0xA5 with latency from line fall to rd_valid
    auto_rd = 1'b1;
    lat = 0;
    fork
      send_push(8'hA5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        while (!rif.rd_valid && lat < 400) begin
          @(posedge clk_bus);
          #1;
          lat++;
        end
      end
    join
    n_cmp++;
    if (lat < 162 || lat > 163) begin
      n_err++;
      $display("FAIL a5_latency: got %0d cycles, expected 162..163", lat);
    end
    drain();

    // 7 bits odd parity: correct then wrong parity bit
    send_push(8'h41, 7, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_push(8'h41, 7, 1, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();

    // Short low glitch must be rejected by the start-bit check
    p0 = n_popped;
    rxd_in = 1'b0;
    repeat (5) @(posedge clk_bus);
    #1;
    idle(64);
    check("glitch_level", 32'(rif.fifo_level), 32'd0);
    check("glitch_pops",  32'(n_popped - p0), 32'd0);

    // 8N2 with bad second stop bit, then a long break
    send_push(8'h3C, 8, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    drain();
    p0 = n_popped;
    model_push(expect_entry(8'h00, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    rxd_in = 1'b0;
    repeat (40 * cur_div) @(posedge clk_bus);
    #1;
    check("break_entries_low", 32'(n_popped - p0), 32'd1);
    idle(40);
    check("break_entries_high", 32'(n_popped - p0), 32'd1);

    // Divisor below 8 behaves as 8
    set_div(3);
    send_push(8'($urandom), 8, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    drain();

    // Randomised formats, divisors, parity errors and framing errors
    for (int k = 0; k < 24; k++) begin
      int dsel;
      dsel = $urandom_range(0, 4);
      set_div(dsel == 0 ? 5 : dsel == 1 ? 8 : dsel == 2 ? 11 : dsel == 3 ? 16 : 23);
      send_push(8'($urandom), $urandom_range(5, 8), $urandom_range(0, 3), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
      idle($urandom_range(2, 30));
    end
    drain();

    // Fill beyond depth without reading: 17th is dropped and overrun set
    set_div(16);
    auto_rd = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      send_push(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
    end
    idle(4);
    check("full_level",   32'(rif.fifo_level), 32'(exp_q.size()));
    check("full_overrun", 32'(overrun), 32'(model_ovr));
    check("full_head",    32'(rif.rd_data), 32'(exp_q[0]));
    clear_overrun = 1'b1;
    @(posedge clk_bus);
    #1;
    clear_overrun = 1'b0;
    model_ovr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'(model_ovr));
    drain();

    // Fill to depth, then pop exactly on the 17th push cycle
    auto_rd = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      send_push(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(2);
    end
    fork
      send_frame(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, e17);
      begin
        repeat (161) @(posedge clk_bus);
        #1;
        check("head_before_pop", 32'(rif.rd_data), 32'(exp_q[0]));
        man_pop = 1'b1;
        @(posedge clk_bus);
        #1;
        man_pop = 1'b0;
        void'(exp_q.pop_front());
      end
    join
    model_push(e17);
    idle(3);
    check("pushpop_level",   32'(rif.fifo_level), 32'(exp_q.size()));
    check("pushpop_overrun", 32'(overrun), 32'(model_ovr));
    check("pushpop_head",    32'(rif.rd_data), 32'(exp_q[0]));
    drain();

    // Reset in the middle of a data bit with entries queued
    auto_rd = 1'b0;
    send_push(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    send_push(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    check("pre_reset_level", 32'(rif.fifo_level), 32'(exp_q.size()));
    data_bits = 2'b11; parity_mode = 2'b00; stop2 = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd_in = 1'b0;
    repeat (7) @(posedge clk_bus);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_ovr = 1'b0;
    check("midreset_rd_valid", 32'(rif.rd_valid), 32'd0);
    check("midreset_level",    32'(rif.fifo_level), 32'(exp_q.size()));
    check("midreset_rd_data",  32'(rif.rd_data), 32'd0);
    check("midreset_overrun",  32'(overrun), 32'(model_ovr));
    rxd_in = 1'b1;
    repeat (3) @(posedge clk_bus);
    #1;
    rst = 1'b0;
    idle(5);
    auto_rd = 1'b1;
    send_push(8'($urandom), 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    drain();

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
